stopwatch_cu: RTL



---
 rtl/stopwatch_cu.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_cu.sv
// -----------------------------------------------------------------------------
// stopwatch_cu
//   Control unit for the stopwatch datapath. Each raw push-button goes through
//   a 2-flop synchronizer, a debouncer and a rising-edge detector. A Moore FSM
//   turns the resulting press pulses into the datapath controls.
//
//   Configuration macro: STOPWATCH_LAP_EN
//     defined   : save/restore channels and lap pulse logic are built.
//     undefined : i_btn_save / i_btn_restore are ignored, o_save / o_restore
//                 are constant 0, and only two conditioning channels exist.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed before a debounced level changes (>= 2)
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   i_btn_runstop  in   raw run/stop button
//   i_btn_clear    in   raw clear button
//   i_btn_save     in   raw lap-save button
//   i_btn_restore  in   raw lap-restore button
//   o_runstop      out  1 while running
//   o_clear        out  one-cycle clear pulse
//   o_save         out  one-cycle lap-save pulse
//   o_restore      out  one-cycle lap-restore pulse
//   o_state        out  FSM state (0 STOP, 1 RUN, 2 CLEAR)
// -----------------------------------------------------------------------------
module stopwatch_cu #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_runstop,
  input  logic       i_btn_clear,
  input  logic       i_btn_save,
  input  logic       i_btn_restore,
  output logic       o_runstop,
  output logic       o_clear,
  output logic       o_save,
  output logic       o_restore,
  output logic [1:0] o_state
);

`ifdef STOPWATCH_LAP_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 2;
`endif

  // The counter holds values up to DEBOUNCE_CYCLES. Together with the
  // synchronizer and edge detector this puts the debounced rise at edge
  // DEBOUNCE_CYCLES+2 after the raw input is first sampled high.
  localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES);

  logic [NCH-1:0] w_btn;
  logic [NCH-1:0] w_press;

`ifdef STOPWATCH_LAP_EN
  assign w_btn = {i_btn_restore, i_btn_save, i_btn_clear, i_btn_runstop};
`else
  assign w_btn = {i_btn_clear, i_btn_runstop};
  // Lap buttons are deliberately left unconnected in this build.
  logic w_unused_lap;
  assign w_unused_lap = i_btn_save | i_btn_restore;
`endif

  // ---------------------------------------------------------------------------
  // Per-button conditioning channels
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic          r_sync0;
    logic          r_sync1;
    logic          r_deb;
    logic          r_deb_prev;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync0    <= 1'b0;
        r_sync1    <= 1'b0;
        r_deb      <= 1'b0;
        r_deb_prev <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_sync0    <= w_btn[gi];
        r_sync1    <= r_sync0;
        r_deb_prev <= r_deb;
        // Any sample that agrees with the debounced level restarts the count,
        // so a glitch has to persist for the full window to be accepted.
        if (r_sync1 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == TERM) begin
          r_deb <= r_sync1;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end

    // Rising edge of the debounced level only; releases give no pulse.
    assign w_press[gi] = r_deb & ~r_deb_prev;
  end

  logic w_p_rs;
  logic w_p_clr;
  assign w_p_rs  = w_press[0];
  assign w_p_clr = w_press[1];

`ifdef STOPWATCH_LAP_EN
  logic w_p_sv;
  logic w_p_rt;
  assign w_p_sv = w_press[2];
  assign w_p_rt = w_press[3];
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t r_state;
  logic   r_runstop;
  logic   r_clear;
`ifdef STOPWATCH_LAP_EN
  logic   r_save;
  logic   r_restore;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_STOP;
      r_runstop <= 1'b0;
      r_clear   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_save    <= 1'b0;
      r_restore <= 1'b0;
`endif
    end else begin
      r_clear   <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      r_save    <= 1'b0;
      r_restore <= 1'b0;
`endif
      case (r_state)
        ST_STOP: begin
          // Priority runstop > clear > save > restore; losers are dropped.
          if (w_p_rs) begin
            r_state   <= ST_RUN;
            r_runstop <= 1'b1;
          end else if (w_p_clr) begin
            r_state <= ST_CLEAR;
            r_clear <= 1'b1;
          end else begin
`ifdef STOPWATCH_LAP_EN
            r_save    <= w_p_sv;
            r_restore <= w_p_rt & ~w_p_sv;
`endif
          end
        end
        ST_RUN: begin
          // A save in RUN is honoured even if runstop stops the watch.
`ifdef STOPWATCH_LAP_EN
          r_save <= w_p_sv;
`endif
          if (w_p_rs) begin
            r_state   <= ST_STOP;
            r_runstop <= 1'b0;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_STOP;
        end
        default: begin
          r_state   <= ST_STOP;
          r_runstop <= 1'b0;
        end
      endcase
    end
  end

  assign o_runstop = r_runstop;
  assign o_clear   = r_clear;
  assign o_state   = r_state;
`ifdef STOPWATCH_LAP_EN
  assign o_save    = r_save;
  assign o_restore = r_restore;
`else
  assign o_save    = 1'b0;
  assign o_restore = 1'b0;
`endif

endmodule
